// File: rtl/line_render.sv
`default_nettype none
// ============================================================================
// Module      : line_render
// Description : Double-buffers one captured line and serializes it pixel by
//               pixel on the pixel tick. Optional collision flag is built
//               when LINE_RENDER_COLLIDE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module line_render #(
    parameter int          WIDTH    = 640,
    parameter logic [11:0] FG_COLOR = 12'hFFF,
    parameter logic [11:0] BG_COLOR = 12'h000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] line_i,
    input  logic             load_i,
    input  logic             start_i,
    input  logic             pix_en_i,
    input  logic [9:0]       player_x_i,
    output logic             pixel_o,
    output logic [11:0]      rgb_o,
    output logic [9:0]       x_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             hit_o
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic [9:0] C_LAST = 10'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] stage_q, stage_d;
    logic [WIDTH-1:0] active_q, active_d;
    logic             pending_q, pending_d;
    logic [9:0]       cnt_q, cnt_d;
    logic             pixel_q, pixel_d;
    logic [11:0]      rgb_q, rgb_d;
    logic [9:0]       x_q, x_d;
    logic             done_q, done_d;

    logic             start_ok;
    logic             cur_bit;

    assign start_ok = (state_q == IDLE) && start_i;
    // Pixel 0 is the oldest bit, so the scan walks from the MSB down.
    assign cur_bit  = active_q[C_LAST - cnt_q];

    always_comb begin
        state_d   = state_q;
        stage_d   = stage_q;
        active_d  = active_q;
        pending_d = pending_q;
        cnt_d     = cnt_q;
        pixel_d   = pixel_q;
        rgb_d     = rgb_q;
        x_d       = x_q;
        done_d    = 1'b0;

        if (load_i) begin
            stage_d   = line_i;
            pending_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (pix_en_i) begin
                    pixel_d = 1'b0;
                    rgb_d   = 12'h000;
                end
                if (start_i) begin
                    // A line arriving with the start is newer than the staged one.
                    if (load_i) begin
                        active_d  = line_i;
                        pending_d = 1'b0;
                    end else if (pending_q) begin
                        active_d  = stage_q;
                        pending_d = 1'b0;
                    end
                    cnt_d   = 10'd0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (pix_en_i) begin
                    pixel_d = cur_bit;
                    rgb_d   = cur_bit ? FG_COLOR : BG_COLOR;
                    x_d     = cnt_q;
                    if (cnt_q == C_LAST) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 10'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            stage_q   <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
            cnt_q     <= 10'd0;
            pixel_q   <= 1'b0;
            rgb_q     <= 12'h000;
            x_q       <= 10'd0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            stage_q   <= stage_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            pixel_q   <= pixel_d;
            rgb_q     <= rgb_d;
            x_q       <= x_d;
            done_q    <= done_d;
        end
    end

`ifdef LINE_RENDER_COLLIDE_EN
    logic hit_q, hit_d;

    always_comb begin
        hit_d = hit_q;
        if (start_ok) begin
            hit_d = 1'b0;
        end else if ((state_q == SCAN) && pix_en_i && cur_bit && (cnt_q == player_x_i)) begin
            hit_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hit_q <= 1'b0;
        end else begin
            hit_q <= hit_d;
        end
    end

    assign hit_o = hit_q;
`else
    logic unused_collide;
    assign unused_collide = ^{player_x_i, start_ok};
    assign hit_o          = 1'b0;
`endif

    assign pixel_o = pixel_q;
    assign rgb_o   = rgb_q;
    assign x_o     = x_q;
    assign busy_o  = (state_q == SCAN);
    assign done_o  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_line_render.sv
`default_nettype none
// ============================================================================
// Module      : tb_line_render
// Description : Directed self-checking bench for line_render.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_line_render;

    localparam int          W  = 640;
    localparam logic [11:0] FG = 12'hFFF;
    localparam logic [11:0] BG = 12'h000;
`ifdef LINE_RENDER_COLLIDE_EN
    localparam bit COLLIDE = 1'b1;
`else
    localparam bit COLLIDE = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_i = 1'b1;
    logic [W-1:0] line_i = '0;
    logic         load_i = 1'b0;
    logic         start_i = 1'b0;
    logic         pix_en_i = 1'b0;
    logic [9:0]   player_x_i = 10'd0;
    logic         pixel_o;
    logic [11:0]  rgb_o;
    logic [9:0]   x_o;
    logic         busy_o;
    logic         done_o;
    logic         hit_o;

    int checks = 0;
    int errors = 0;

    line_render #(.WIDTH(W), .FG_COLOR(FG), .BG_COLOR(BG)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .line_i     (line_i),
        .load_i     (load_i),
        .start_i    (start_i),
        .pix_en_i   (pix_en_i),
        .player_x_i (player_x_i),
        .pixel_o    (pixel_o),
        .rgb_o      (rgb_o),
        .x_o        (x_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .hit_o      (hit_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] line;
        bit           bypass;
        logic [9:0]   px;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock with the given strobes; outputs are sampled 1ns after the edge.
    task automatic step(input logic ld, input logic st, input logic pe);
        @(negedge clk);
        load_i   = ld;
        start_i  = st;
        pix_en_i = pe;
        @(posedge clk);
        #1;
        load_i   = 1'b0;
        start_i  = 1'b0;
        pix_en_i = 1'b0;
    endtask

    // Ticks every 2 cycles until WIDTH pixels are seen, comparing against exp.
    task automatic do_scan(input logic [W-1:0] exp, input int load_at,
                           input logic [W-1:0] ld_line, input int gap_at,
                           input int start_at, input string tag,
                           output int hit_first);
        int k = 0;
        int bad = 0;
        int dones = 0;
        int cyc = 0;
        hit_first = -1;
        while (k < W && cyc < 4 * W) begin
            step(1'b0, 1'b0, 1'b0);
            cyc++;
            if (done_o) dones++;
            if (k == gap_at) begin
                for (int g = 0; g < 5; g++) begin
                    step(1'b0, 1'b0, 1'b0);
                    cyc++;
                    if (x_o !== 10'(k - 1) || pixel_o !== exp[W - k]) bad++;
                end
            end
            if (k == load_at) line_i = ld_line;
            step(k == load_at, k == start_at, 1'b1);
            cyc++;
            if (pixel_o !== exp[W-1-k] || x_o !== 10'(k) ||
                rgb_o !== (exp[W-1-k] ? FG : BG)) bad++;
            if (busy_o !== (k != W - 1)) bad++;
            if (done_o) dones++;
            if (hit_o && hit_first < 0) hit_first = k;
            k++;
        end
        step(1'b0, 1'b0, 1'b0);
        if (done_o) dones++;
        check({tag, " ticks"}, k, W);
        check({tag, " pixels"}, bad, 0);
        check({tag, " done pulses"}, dones, 1);
        check({tag, " busy low"}, busy_o, 0);
    endtask

    initial begin
        vec_t         vecs[5];
        logic [W-1:0] one;
        logic [W-1:0] all1;
        logic [W-1:0] all0;
        logic [W-1:0] alt;
        int           hf;
        int           exp_hit;

        one  = {{(W-1){1'b0}}, 1'b1};
        all1 = '1;
        all0 = '0;
        alt  = {(W/2){2'b10}};

        vecs[0].line = one << (W - 1); vecs[0].bypass = 1'b0; vecs[0].px = 10'd5;
        vecs[1].line = one;            vecs[1].bypass = 1'b1; vecs[1].px = 10'd639;
        vecs[2].line = alt;            vecs[2].bypass = 1'b0; vecs[2].px = 10'd2;
        vecs[3].line = one << 319;     vecs[3].bypass = 1'b0; vecs[3].px = 10'd320;
        vecs[4].line = one << 319;     vecs[4].bypass = 1'b0; vecs[4].px = 10'd321;

        repeat (2) @(posedge clk);
        #1;
        check("reset pixel", pixel_o, 0);
        check("reset rgb", rgb_o, 0);
        check("reset x", x_o, 0);
        check("reset busy", busy_o, 0);
        check("reset done", done_o, 0);
        check("reset hit", hit_o, 0);
        @(negedge clk);
        rst_i = 1'b0;

        for (int i = 0; i < 5; i++) begin
            player_x_i = vecs[i].px;
            line_i     = vecs[i].line;
            if (vecs[i].bypass) begin
                step(1'b1, 1'b1, 1'b0);
            end else begin
                step(1'b1, 1'b0, 1'b0);
                step(1'b0, 1'b1, 1'b0);
            end
            check($sformatf("vec%0d start busy", i), busy_o, 1);
            check($sformatf("vec%0d start clears hit", i), hit_o, 0);
            do_scan(vecs[i].line, -1, all0, -1, -1, $sformatf("vec%0d", i), hf);
            exp_hit = (COLLIDE && vecs[i].line[W-1-int'(vecs[i].px)]) ? int'(vecs[i].px) : -1;
            check($sformatf("vec%0d hit column", i), hf, exp_hit);
            check($sformatf("vec%0d hit sticky", i), hit_o, exp_hit >= 0);
        end

        // Double buffer: B loaded mid-scan must not disturb A.
        line_i = all1;
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        do_scan(all1, 100, all0, -1, -1, "dbuf A", hf);
        step(1'b0, 1'b0, 1'b1);
        check("blank pixel", pixel_o, 0);
        check("blank rgb", rgb_o, 0);
        check("blank x holds", x_o, W - 1);
        step(1'b0, 1'b1, 1'b0);
        do_scan(all0, -1, all0, -1, -1, "dbuf B", hf);
        line_i = all1;
        step(1'b0, 1'b1, 1'b0);
        do_scan(all0, -1, all0, -1, -1, "dbuf repeat", hf);

        // Start with a tick in the same cycle, gapped ticks, start during scan.
        line_i = alt;
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        check("start+tick busy", busy_o, 1);
        check("start+tick x holds", x_o, W - 1);
        do_scan(alt, -1, all0, 200, 300, "gap", hf);

        // Reset in the middle of a scan.
        line_i = all1;
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        for (int k = 0; k <= 300; k++) step(1'b0, 1'b0, 1'b1);
        check("pre-reset x", x_o, 300);
        check("pre-reset pixel", pixel_o, 1);
        @(negedge clk);
        rst_i = 1'b1;
        #1;
        check("mid reset busy", busy_o, 0);
        check("mid reset pixel", pixel_o, 0);
        check("mid reset x", x_o, 0);
        check("mid reset rgb", rgb_o, 0);
        @(negedge clk);
        rst_i = 1'b0;
        step(1'b0, 1'b1, 1'b0);
        do_scan(all0, -1, all0, -1, -1, "post reset", hf);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/line_render.md
# line_render

Downstream consumer of the 640-bit scrolling line produced by the line generator. It double-buffers one captured line and serializes it pixel by pixel on the VGA pixel-enable tick, producing a 1-bit pixel and a 12-bit colour for the display path. It also optionally flags a collision between a lit pixel and the player column.

## Interface
Parameters:
- `WIDTH`, 640: line length in pixels; also the number of pixels per scan.
- `FG_COLOR`, 12'hFFF: RGB444 value for a lit pixel.
- `BG_COLOR`, 12'h000: RGB444 value for an unlit pixel during a scan.

Ports:
- `clk_i`, in, 1: system clock; all state changes on its rising edge.
- `rst_i`, in, 1: reset, asynchronous, active-high.
- `line_i`, in, WIDTH: line from the generator. Bit 0 is the newest bit; bit WIDTH-1 is the oldest.
- `load_i`, in, 1: capture `line_i` into the staging register and set `pending`.
- `start_i`, in, 1: begin a scan (row start from VGA timing).
- `pix_en_i`, in, 1: pixel tick (one-cycle enable).
- `player_x_i`, in, 10: player column, 0..WIDTH-1.
- `pixel_o`, out, 1: current pixel value.
- `rgb_o`, out, 12: current pixel colour.
- `x_o`, out, 10: index of the pixel currently on `pixel_o`/`rgb_o`.
- `busy_o`, out, 1: high while in SCAN.
- `done_o`, out, 1: one-cycle pulse after the last pixel of a scan.
- `hit_o`, out, 1: sticky collision flag.

## Operation
- Registers:
  - `stage[WIDTH-1:0]`: staging line.
  - `active[WIDTH-1:0]`: line being scanned.
  - `pending`.
  - `cnt[9:0]`.
  - state ∈ {IDLE, SCAN}.
- Reset values:
  - state=IDLE; `stage`, `active`, `cnt`, `pending` = 0.
  - `pixel_o`=0, `rgb_o`=12'h000, `x_o`=0, `busy_o`=0, `done_o`=0, `hit_o`=0.
- `load_i` is accepted in any state: `stage`<=`line_i`, `pending`<=1. It never disturbs `active` mid-scan.
- IDLE, on `start_i`:
  - If `pending`: `active`<=`stage` and `pending`<=0. If `load_i` is high in the same cycle, `active`<=`line_i` directly (bypass) and `pending`<=0.
  - If not `pending`: `active` is kept, so the previous line is repeated.
  - `cnt`<=0; go to SCAN.
- SCAN, on each `pix_en_i`:
  - `pixel_o`<=`active[WIDTH-1-cnt]`, so pixel 0 is the oldest bit (left edge).
  - `rgb_o`<=`pixel_o` ? FG_COLOR : BG_COLOR, taken from the same bit.
  - `x_o`<=`cnt`; `cnt`<=`cnt`+1.
  - When `cnt`==WIDTH-1 is emitted: go to IDLE and pulse `done_o` in that same update.
- SCAN, without `pix_en_i`: all outputs hold.
- `start_i` during SCAN is ignored; the scan is not restarted.
- On entering IDLE after the last pixel's display slot: the next `pix_en_i` in IDLE drives `pixel_o`=0 and `rgb_o`=12'h000 (blank). `x_o` holds WIDTH-1.
- `busy_o` = (state==SCAN).
- `cnt` never exceeds WIDTH-1; there is no wrap inside a scan.
- Asserting `rst_i` mid-scan aborts immediately to the reset values. `pending` and `stage` are lost.

## Timing
- `start_i` sampled at edge N puts the block in SCAN from N. A `pix_en_i` in the same cycle as `start_i` is not consumed as a pixel.
- The first `pix_en_i` at edge M>N presents pixel 0 after edge M (1-cycle latency). Each later tick advances exactly one pixel.
- A full scan consumes exactly WIDTH ticks. `done_o` is high for the single cycle following the edge that presents pixel WIDTH-1.
- The earliest next `start_i` is accepted at the edge after `done_o`'s edge (state is IDLE).
- `load_i` to `stage` takes 1 cycle. `stage` to `active` happens only at an accepted `start_i`.

## Configuration
- `LINE_RENDER_COLLIDE_EN` defined:
  - `hit_o` is set when a `pix_en_i` update presents `pixel_o`=1 with `cnt`==`player_x_i`.
  - It stays set until an accepted `start_i` or `rst_i` clears it. Clearing on `start_i` takes priority over setting, which cannot occur in that cycle anyway.
- Not defined: `player_x_i` is unused, `hit_o` is tied to 0, and no compare logic is built.

## Test plan
- Reset mid-scan: pulse `rst_i` at pixel 300 → same cycle `busy_o`=0, `pixel_o`=0, `x_o`=0, `rgb_o`=000; a following `start_i` scans `active`=0.
- Single-bit line: `line_i`=1<<639, `load_i`, then `start_i`, then 640 ticks spaced 2 cycles apart → pixel 0 lit (`rgb_o`=FFF), pixels 1..639 show 000, `done_o` pulses once after pixel 639, `busy_o` falls.
- Double buffer: load A (all 1s), start, load B (all 0s) at pixel 100 → pixels 100..639 stay 1; the next start scans B; a third start with no load repeats B.
- Simultaneous events:
  - `load_i`+`start_i` same cycle with `line_i`=1<<0 → pixel 639 lit only.
  - `start_i` with `pix_en_i` same cycle → first pixel appears on the next tick.
  - `start_i` during SCAN → ignored, `x_o` continues.
- Gapped ticks: `pix_en_i` held low 5 cycles mid-scan → outputs hold, no pixel skipped, total tick count to `done_o` is 640.
- Collision (macro on): `line_i` bit 639-320 set, `player_x_i`=320 → `hit_o` rises with pixel 320 and holds until the next start. `player_x_i`=321 → `hit_o` stays 0. Macro off → `hit_o` constantly 0.
